// File: rtl/wb_pkg.sv
// Writeback arbiter shared types: load funct3 encodings and the
// divider-result queue entry.
package wb_pkg;

  localparam int WB_XMAX = 64;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [4:0]         rd;
    logic [WB_XMAX-1:0] result;
    logic [WB_XMAX-1:0] pc;
    logic [31:0]        inst;
  } wb_entry_t;

endpackage

// File: rtl/wb_div_fifo.sv
// Divider-result queue: power-of-two ring buffer with push/pop in the
// same cycle; caller never pushes when full nor pops when empty.
module wb_div_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wb_entry_t              din,
  input  logic                   pop,
  output wb_entry_t              dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t       mem_q [DEPTH];
  wb_entry_t       mem_d [DEPTH];
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW:0]     cnt_q, cnt_d;

  // next pointers, occupancy and storage contents
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    if (push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end
  end

  // pointer and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // storage needs no reset; occupancy guards every read
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;
  assign full  = (cnt_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/stage_writeback_arb.sv
// Writeback arbiter: main pipe retires with zero latency, divider results
// bypass or queue. Optional retire trace under WB_TRACE_EN.
module stage_writeback_arb
  import wb_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int DIVQ_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          m_valid,
  input  logic [XLEN-1:0]               m_pc,
  input  logic [31:0]                   m_inst,
  input  logic [XLEN-1:0]               m_alu_result,
  input  logic [XLEN-1:0]               m_mem_data,
  input  logic [4:0]                    m_rd,
  input  logic                          m_reg_we,
  input  logic                          m_load,
  input  logic [2:0]                    m_funct3,
  input  logic [1:0]                    m_byte_offset,
  output logic                          m_stall,
  input  logic                          d_valid,
  input  logic [4:0]                    d_rd,
  input  logic [XLEN-1:0]               d_result,
  input  logic [XLEN-1:0]               d_pc,
  input  logic [31:0]                   d_inst,
  output logic                          d_ready,
  output logic                          rf_we,
  output logic [4:0]                    rf_dst,
  output logic [XLEN-1:0]               rf_data,
  output logic [$clog2(DIVQ_DEPTH):0]   q_count,
  output logic                          q_full
`ifdef WB_TRACE_EN
  ,
  output logic                          trace_valid,
  output logic [XLEN-1:0]               trace_pc,
  output logic [31:0]                   trace_inst
`endif
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0]   starve_q, starve_d;
  logic [7:0]      ld_b;
  logic [15:0]     ld_h;
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] m_wdata;
  logic            main_ret;
  logic            q_empty;
  logic            pop;
  logic            byp;
  logic            push;
  logic            sel_we;
  logic [XLEN-1:0] ret_pc;
  logic [31:0]     ret_inst;
  wb_entry_t       d_ent;
  wb_entry_t       head;
  logic            unused_hi;

  // load data alignment and extension
  always_comb begin
    ld_b = m_mem_data[{m_byte_offset, 3'b000} +: 8];
    ld_h = m_byte_offset[1] ? m_mem_data[31:16] : m_mem_data[15:0];
    case (m_funct3)
      F3_LB:   ld_data = {{(XLEN-8){ld_b[7]}}, ld_b};
      F3_LBU:  ld_data = {{(XLEN-8){1'b0}}, ld_b};
      F3_LH:   ld_data = {{(XLEN-16){ld_h[15]}}, ld_h};
      F3_LHU:  ld_data = {{(XLEN-16){1'b0}}, ld_h};
      default: ld_data = m_mem_data;
    endcase
    m_wdata = m_load ? ld_data : m_alu_result;
  end

  assign m_stall = (starve_q == SW'(STARVE_LIMIT));
  assign d_ready = !q_full;
  assign q_empty = (q_count == '0);

  always_comb begin
    d_ent        = '0;
    d_ent.rd     = d_rd;
    d_ent.result = WB_XMAX'(d_result);
    d_ent.pc     = WB_XMAX'(d_pc);
    d_ent.inst   = d_inst;
  end

  wb_div_fifo #(
    .DEPTH (DIVQ_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (d_ent),
    .pop   (pop),
    .dout  (head),
    .count (q_count),
    .full  (q_full)
  );

  // source select: main, then queue head, then divider bypass
  always_comb begin
    main_ret = !rst && m_valid && !m_stall && (m_inst != '0);
    pop      = !rst && !main_ret && !q_empty;
    byp      = !rst && !main_ret && q_empty && d_valid;
    push     = !rst && d_valid && d_ready && !byp;
    sel_we   = 1'b0;
    rf_dst   = m_rd;
    rf_data  = m_wdata;
    ret_pc   = m_pc;
    ret_inst = m_inst;
    unique case (1'b1)
      main_ret: begin
        sel_we = m_reg_we;
      end
      pop: begin
        sel_we   = 1'b1;
        rf_dst   = head.rd;
        rf_data  = head.result[XLEN-1:0];
        ret_pc   = head.pc[XLEN-1:0];
        ret_inst = head.inst;
      end
      byp: begin
        sel_we   = 1'b1;
        rf_dst   = d_rd;
        rf_data  = d_result;
        ret_pc   = d_pc;
        ret_inst = d_inst;
      end
      default: ;
    endcase
    rf_we = sel_we && (rf_dst != 5'd0);
  end

  // starvation count: main retiring over a waiting queue
  always_comb begin
    starve_d = '0;
    if (main_ret && !q_empty) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // starvation register
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

`ifdef WB_TRACE_EN
  logic            trace_valid_q, trace_valid_d;
  logic [XLEN-1:0] trace_pc_q, trace_pc_d;
  logic [31:0]     trace_inst_q, trace_inst_d;

  // capture whichever source retired; hold otherwise
  always_comb begin
    trace_valid_d = main_ret || pop || byp;
    trace_pc_d    = trace_pc_q;
    trace_inst_d  = trace_inst_q;
    if (trace_valid_d) begin
      trace_pc_d   = ret_pc;
      trace_inst_d = ret_inst;
    end
  end

  // trace registers
  always_ff @(posedge clk) begin
    if (rst) begin
      trace_valid_q <= 1'b0;
      trace_pc_q    <= '0;
      trace_inst_q  <= '0;
    end else begin
      trace_valid_q <= trace_valid_d;
      trace_pc_q    <= trace_pc_d;
      trace_inst_q  <= trace_inst_d;
    end
  end

  assign trace_valid = trace_valid_q;
  assign trace_pc    = trace_pc_q;
  assign trace_inst  = trace_inst_q;
  assign unused_hi   = ^{head.result, head.pc};
`else
  assign unused_hi   = ^{head.result, head.pc, ret_pc, ret_inst};
`endif

endmodule

// File: tb/tb_stage_writeback_arb.sv
// Randomized bench for stage_writeback_arb against a queue-based model.
// Trace checks compile in when WB_TRACE_EN is defined.
module tb_stage_writeback_arb;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk;
  logic        rst;
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_alu_result;
  logic [31:0] m_mem_data;
  logic [4:0]  m_rd;
  logic        m_reg_we;
  logic        m_load;
  logic [2:0]  m_funct3;
  logic [1:0]  m_byte_offset;
  logic        m_stall;
  logic        d_valid;
  logic [4:0]  d_rd;
  logic [31:0] d_result;
  logic [31:0] d_pc;
  logic [31:0] d_inst;
  logic        d_ready;
  logic        rf_we;
  logic [4:0]  rf_dst;
  logic [31:0] rf_data;
  logic [1:0]  q_count;
  logic        q_full;
`ifdef WB_TRACE_EN
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [31:0] trace_inst;
`endif

  stage_writeback_arb #(
    .XLEN         (XLEN),
    .DIVQ_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .m_valid       (m_valid),
    .m_pc          (m_pc),
    .m_inst        (m_inst),
    .m_alu_result  (m_alu_result),
    .m_mem_data    (m_mem_data),
    .m_rd          (m_rd),
    .m_reg_we      (m_reg_we),
    .m_load        (m_load),
    .m_funct3      (m_funct3),
    .m_byte_offset (m_byte_offset),
    .m_stall       (m_stall),
    .d_valid       (d_valid),
    .d_rd          (d_rd),
    .d_result      (d_result),
    .d_pc          (d_pc),
    .d_inst        (d_inst),
    .d_ready       (d_ready),
    .rf_we         (rf_we),
    .rf_dst        (rf_dst),
    .rf_data       (rf_data),
    .q_count       (q_count),
    .q_full        (q_full)
`ifdef WB_TRACE_EN
    ,
    .trace_valid   (trace_valid),
    .trace_pc      (trace_pc),
    .trace_inst    (trace_inst)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  int          starve;
  int          n_tests;
  int          n_fail;
  bit          tr_known;
  logic        exp_tv;
  logic [31:0] exp_tpc;
  logic [31:0] exp_tinst;
  bit          m_ret;
  bit          d_acc;
  logic        o_rf_we;
  logic [31:0] o_rf_data;
  logic [4:0]  o_rf_dst;
  logic        o_m_stall;
  logic        o_q_full;
  logic        o_d_ready;
  logic [1:0]  o_q_count;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] align(logic [2:0] f3, logic [31:0] mem,
                                        logic [1:0] off);
    logic [31:0] sb;
    logic [31:0] sh;
    sb = mem >> (8 * off);
    sh = mem >> (16 * off[1]);
    case (f3)
      3'd0:    return 32'($signed(sb[7:0]));
      3'd4:    return 32'(sb[7:0]);
      3'd1:    return 32'($signed(sh[15:0]));
      3'd5:    return 32'(sh[15:0]);
      default: return mem;
    endcase
  endfunction

  // one cycle: inputs already driven at the negedge
  task automatic step();
    bit          stall;
    bit          ready;
    bit          byp;
    bit          any;
    int          sz;
    logic [31:0] pc;
    logic [31:0] inst;
    ent_t        e;
    #1;
    o_rf_we   = rf_we;
    o_rf_data = rf_data;
    o_rf_dst  = rf_dst;
    o_m_stall = m_stall;
    o_q_full  = q_full;
    o_d_ready = d_ready;
    o_q_count = q_count;
`ifdef WB_TRACE_EN
    if (tr_known) begin
      chk("trace_valid", trace_valid, exp_tv);
      chk("trace_pc", trace_pc, exp_tpc);
      chk("trace_inst", trace_inst, exp_tinst);
    end
`endif
    m_ret = 0;
    d_acc = 0;
    if (rst) begin
      chk("rst_rf_we", rf_we, 0);
      mq.delete();
      starve    = 0;
      exp_tv    = 0;
      exp_tpc   = 0;
      exp_tinst = 0;
      tr_known  = 1;
    end else begin
      sz    = mq.size();
      stall = (starve == LIMIT);
      ready = (sz < DEPTH);
      chk("m_stall", m_stall, stall);
      chk("d_ready", d_ready, ready);
      chk("q_count", q_count, sz);
      chk("q_full", q_full, sz == DEPTH);
      m_ret = m_valid && !stall && (m_inst != 0);
      byp   = 0;
      any   = 1;
      pc    = 0;
      inst  = 0;
      if (m_ret) begin
        chk("main_we", rf_we, m_reg_we && (m_rd != 0));
        chk("main_dst", rf_dst, m_rd);
        chk("main_data", rf_data,
            m_load ? align(m_funct3, m_mem_data, m_byte_offset)
                   : m_alu_result);
        pc   = m_pc;
        inst = m_inst;
      end else if (sz > 0) begin
        e = mq.pop_front();
        chk("pop_we", rf_we, e.rd != 0);
        chk("pop_dst", rf_dst, e.rd);
        chk("pop_data", rf_data, e.res);
        pc   = e.pc;
        inst = e.inst;
      end else if (d_valid) begin
        byp = 1;
        chk("byp_we", rf_we, d_rd != 0);
        chk("byp_dst", rf_dst, d_rd);
        chk("byp_data", rf_data, d_result);
        pc   = d_pc;
        inst = d_inst;
      end else begin
        any = 0;
        chk("idle_we", rf_we, 0);
      end
      d_acc = d_valid && ready;
      if (d_acc && !byp) begin
        mq.push_back('{rd: d_rd, res: d_result, pc: d_pc, inst: d_inst});
      end
      if (stall) starve = 0;
      else if (sz > 0 && m_ret) starve = starve + 1;
      else starve = 0;
      exp_tv = any;
      if (any) begin
        exp_tpc   = pc;
        exp_tinst = inst;
      end
    end
    @(negedge clk);
  endtask

  task automatic new_main(int pv);
    m_valid       = ($urandom_range(99) < pv);
    m_pc          = $urandom & 32'hFFFF_FFFC;
    m_inst        = ($urandom_range(7) == 0) ? 32'h0 : ($urandom | 32'h3);
    m_alu_result  = $urandom;
    m_mem_data    = $urandom;
    m_rd          = 5'($urandom_range(31));
    m_reg_we      = ($urandom_range(7) != 0);
    m_load        = $urandom_range(1);
    m_funct3      = 3'($urandom_range(7));
    m_byte_offset = 2'($urandom_range(3));
  endtask

  task automatic new_div();
    d_rd     = ($urandom_range(5) == 0) ? 5'd0 : 5'($urandom_range(31));
    d_result = $urandom;
    d_pc     = $urandom & 32'hFFFF_FFFC;
    d_inst   = $urandom | 32'h1;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    tr_known = 0;
    starve   = 0;
    rst      = 1;
    new_main(0);
    m_valid  = 0;
    d_valid  = 0;
    new_div();
    @(negedge clk);
    step();
    step();
    rst = 0;
    step();
    chk("rst_q_count", o_q_count, 0);
    chk("rst_d_ready", o_d_ready, 1);
    chk("rst_m_stall", o_m_stall, 0);

    // sign-extended byte and zero-extended half from offset 2
    m_valid = 1; m_inst = 32'h0000_0003; m_load = 1; m_funct3 = 3'd0;
    m_byte_offset = 2'd2; m_mem_data = 32'h80FF_7F01; m_rd = 5'd5;
    m_reg_we = 1;
    step();
    chk("lb_we", o_rf_we, 1);
    chk("lb_dst", o_rf_dst, 5);
    chk("lb_data", o_rf_data, 32'hFFFF_FFFF);
    m_funct3 = 3'd5;
    step();
    chk("lhu_data", o_rf_data, 32'h0000_80FF);

    // divider bypass with main idle
    m_valid = 0; d_valid = 1; d_rd = 5'd7; d_result = 32'h2A;
    step();
    chk("byp_data_k", o_rf_data, 32'h2A);
    chk("byp_dst_k", o_rf_dst, 7);
    d_valid = 0;
    step();
    chk("byp_q_count", o_q_count, 0);

    // main busy: queue fills, then starvation stall drains the head
    new_main(100); m_valid = 1; m_inst = 32'h13; m_reg_we = 1;
    d_valid = 1; new_div(); d_rd = 5'd9;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 2) begin
        chk("full_q_full", o_q_full, 1);
        chk("full_d_ready", o_d_ready, 0);
      end
      if (i == 5) begin
        chk("starve_stall", o_m_stall, 1);
        chk("starve_we", o_rf_we, 1);
        chk("starve_dst", o_rf_dst, 9);
      end
      if (i == 6) chk("starve_clr", o_m_stall, 0);
      if (m_ret) begin
        new_main(100);
        m_valid = 1;
        m_inst  = 32'h13;
      end
      if (d_acc) begin
        new_div();
        d_rd = 5'd9;
      end
    end

    // drain, then a rd 0 divider result goes through the queue
    m_valid = 0; d_valid = 0;
    repeat (3) step();
    m_valid = 1; m_inst = 32'h33;
    d_valid = 1; d_rd = 5'd0; d_pc = 32'h0000_1234; d_inst = 32'h0200_0033;
    step();
    d_valid = 0; m_valid = 0;
    step();
    chk("rd0_we", o_rf_we, 0);
    step();
`ifdef WB_TRACE_EN
    chk("rd0_trace_pc", trace_pc, 32'h0000_1234);
`endif

    // reset with two queued entries discards them
    m_valid = 1; m_inst = 32'h13; d_valid = 1; new_div(); d_rd = 5'd3;
    step();
    new_div(); d_rd = 5'd4;
    step();
    m_valid = 0; d_valid = 0; rst = 1;
    step();
    chk("rst31_we", o_rf_we, 0);
    rst = 0;
    step();
    chk("rst31_q_count", o_q_count, 0);
    chk("rst31_we2", o_rf_we, 0);

    // randomized traffic with shifting main-pipe load
    new_main(50);
    d_valid = 0;
    for (int i = 0; i < 3000; i++) begin
      int pv;
      pv = ((i / 250) % 3 == 0) ? 95 : ((i / 250) % 3 == 1) ? 50 : 10;
      if ($urandom_range(199) == 0) begin
        rst = 1;
        m_valid = 0;
        d_valid = 0;
        step();
        rst = 0;
        new_main(pv);
        continue;
      end
      step();
      if (m_ret || !m_valid || m_inst == 0) new_main(pv);
      if (!d_valid || d_acc) begin
        d_valid = ($urandom_range(99) < 40);
        new_div();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
